// File: rtl/adc_xy_avg.sv
// -----------------------------------------------------------------------------
// adc_xy_avg
//
// Box-car decimating averager for the dual-channel XY ADC sample stream.
// Accumulates 2^LOG2_SAMPLES consecutive accepted sample pairs per channel and
// emits one averaged XY pair per group on a valid/ready output.
//
// Parameters:
//   DATA_BITS     width of each ADC channel sample
//   LOG2_SAMPLES  log2 of samples per group (0 = registered pass-through)
//
// Ports:
//   clk       system clock, all logic on posedge
//   reset     synchronous, active-high reset
//   s_tvalid  upstream sample pair valid
//   s_tready  block can accept the upstream pair this cycle
//   s_adc_x   upstream X sample
//   s_adc_y   upstream Y sample
//   m_tvalid  averaged pair valid
//   m_tready  downstream accepts averaged pair
//   m_adc_x   averaged X
//   m_adc_y   averaged Y
//
// Build option:
//   ADC_XY_AVG_ROUND_EN  when defined, the group sum gets N/2 added before the
//                        shift (round half up); otherwise the shift truncates.
// -----------------------------------------------------------------------------
module adc_xy_avg #(
    parameter int DATA_BITS    = 10,
    parameter int LOG2_SAMPLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [DATA_BITS-1:0] s_adc_x,
    input  logic [DATA_BITS-1:0] s_adc_y,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [DATA_BITS-1:0] m_adc_x,
    output logic [DATA_BITS-1:0] m_adc_y
);

    localparam int N     = 1 << LOG2_SAMPLES;
    localparam int ACC_W = DATA_BITS + LOG2_SAMPLES;
    // A zero-width counter is not legal, so the pass-through build keeps one
    // dummy bit that never leaves zero.
    localparam int CNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt_p0;
    logic [ACC_W-1:0]     acc_x_p0, acc_y_p0;
    logic [ACC_W-1:0]     sum_x_p0, sum_y_p0;
    logic [DATA_BITS-1:0] avg_x_p1, avg_y_p1;
    logic                 vld_p1;
    logic                 is_final;
    logic                 accept;
    logic                 load;

    // Divide the group sum by N. The worst-case sum plus the rounding bias is
    // N*2^DATA_BITS - N/2, which still fits ACC_W bits, so the result never
    // exceeds the full-scale sample value.
    function automatic logic [DATA_BITS-1:0] avg_of(input logic [ACC_W-1:0] sum);
`ifdef ADC_XY_AVG_ROUND_EN
        logic [ACC_W-1:0] biased;
        biased = sum + ACC_W'(N / 2);
        return DATA_BITS'(biased >> LOG2_SAMPLES);
`else
        return DATA_BITS'(sum >> LOG2_SAMPLES);
`endif
    endfunction

    // ---- stage p0: accumulate incoming beats --------------------------------
    assign is_final = (LOG2_SAMPLES == 0) ? 1'b1 : (cnt_p0 == CNT_LAST);
    assign vld_p1   = (state == HOLD);

    // Only the group-closing beat needs the output register, so only that beat
    // waits for an undelivered result; m_tready feeds through combinationally.
    assign s_tready = !(vld_p1 && !m_tready && is_final);
    assign accept   = s_tvalid && s_tready;
    assign load     = accept && is_final;

    assign sum_x_p0 = acc_x_p0 + ACC_W'(s_adc_x);
    assign sum_y_p0 = acc_y_p0 + ACC_W'(s_adc_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0   <= '0;
            acc_x_p0 <= '0;
            acc_y_p0 <= '0;
            avg_x_p1 <= '0;
            avg_y_p1 <= '0;
        end else if (accept) begin
            if (is_final) begin
                cnt_p0   <= '0;
                acc_x_p0 <= '0;
                acc_y_p0 <= '0;
                avg_x_p1 <= avg_of(sum_x_p0);
                avg_y_p1 <= avg_of(sum_y_p0);
            end else begin
                cnt_p0   <= cnt_p0 + CNT_W'(1);
                acc_x_p0 <= sum_x_p0;
                acc_y_p0 <= sum_y_p0;
            end
        end
    end

    // ---- stage p1: output hold controller -----------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // A consume and a fresh load on the same edge keep HOLD with new data.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: begin
                if (load) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (m_tready && !load) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    assign m_tvalid = vld_p1;
    assign m_adc_x  = avg_x_p1;
    assign m_adc_y  = avg_y_p1;

endmodule

// File: doc/adc_xy_avg.md
# adc_xy_avg

Box-car decimating averager for the dual-channel XY ADC sample stream. Consumes the valid/ready XY stream produced by the ADC capture stage, accumulates 2^LOG2_SAMPLES consecutive accepted sample pairs per channel, and emits one averaged XY pair per group on its own valid/ready output. Sits between ADC capture and the display/plot pipeline to cut noise and sample rate.

## Interface

Parameters:
- DATA_BITS, 10, width of each ADC channel sample.
- LOG2_SAMPLES, 2, log2 of samples per average group (0 gives a pure 1-deep register stage).

Ports:
- clk  input  1  system clock; all logic is on posedge clk.
- reset  input  1  synchronous, active-high reset.
- s_tvalid  input  1  upstream sample pair valid.
- s_tready  output  1  block can accept the upstream pair this cycle.
- s_adc_x  input  DATA_BITS  upstream X sample.
- s_adc_y  input  DATA_BITS  upstream Y sample.
- m_tvalid  output  1  averaged pair valid.
- m_tready  input  1  downstream accepts averaged pair.
- m_adc_x  output  DATA_BITS  averaged X.
- m_adc_y  output  DATA_BITS  averaged Y.

## Operation

- N = 2^LOG2_SAMPLES. Internal: sample counter cnt (LOG2_SAMPLES bits, mod N), accumulators acc_x, acc_y (DATA_BITS+LOG2_SAMPLES bits, unsigned).
- Input beat accepted when s_tvalid && s_tready.
- Non-final beat (cnt != N-1): acc += sample, cnt++.
- Final beat (cnt == N-1): m_adc_x/y <= (acc + sample [+ rounding]) >> LOG2_SAMPLES; m_tvalid <= 1; acc <= 0; cnt <= 0.
- Output beat completes when m_tvalid && m_tready; m_tvalid clears unless a new final beat loads the same cycle (then stays 1, new data).
- s_tready = !(m_tvalid && !m_tready && cnt == N-1): non-final beats are always accepted; the final beat stalls only while an undelivered output is held. No output overwrite, no sample dropped.
- Implicitly a 2-state controller: ACCUM (m_tvalid=0) and HOLD (m_tvalid=1); accumulation continues in both.
- LOG2_SAMPLES=0: every accepted beat is final; block is a registered pass-through with full-throughput handshake.
- m_adc_x/y stable while m_tvalid && !m_tready.

## Timing

- Reset: m_tvalid=0, m_adc_x=0, m_adc_y=0, cnt=0, acc_x=acc_y=0; s_tready=1 during and after reset.
- Reset mid-group discards partial accumulation; reset while HOLD discards pending output.
- Latency: m_tvalid asserted the cycle after the final input beat is accepted.
- Throughput: one input per cycle sustained when downstream keeps m_tready=1 (or is ready at least once per N cycles).
- Simultaneous output handshake and final input beat: output consumed and replaced in the same edge, no bubble.
- No combinational path from s_tvalid to s_tready; m_tready→s_tready is combinational.

## Configuration

- ADC_XY_AVG_ROUND_EN defined: add N/2 to the sum before the shift (round half up). Sum ≤ N·(2^DATA_BITS−1)+N/2 fits in DATA_BITS+LOG2_SAMPLES bits; result never exceeds 2^DATA_BITS−1. Ignored when LOG2_SAMPLES=0.
- Not defined: truncating shift (floor).

## Test plan

- Reset then X=1,2,3,4, Y=1023×4 with m_tready=1, LOG2_SAMPLES=2 -> one output X=2 (floor of 2.5), Y=1023, one cycle after 4th accept; with ADC_XY_AVG_ROUND_EN X=3.
- Continuous s_tvalid, m_tready=1, 64 beats -> exactly 16 outputs, s_tready never low, averages match model.
- m_tready=0 after first output, keep feeding -> 3 more beats accepted, 4th stalls (s_tready=0), output held stable; raise m_tready -> old output consumed and new one loaded same edge.
- Assert reset after 2 of 4 beats (X=100,100), then feed 4×X=8 -> output X=8, not contaminated by prior beats.
- All inputs 1023 with rounding enabled -> output 1023 (no overflow); all inputs 0 -> 0.
- LOG2_SAMPLES=0, random stream with random m_tready -> output sequence equals input sequence, no loss or duplication.
